// File: rtl/sr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input and
// the decoder-facing instruction handshake.
interface sr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pcNew_vld;
  logic [31:0] pcNew;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instr_vld;
  logic        instr_rdy;

  modport master (
    output imem_req, imem_addr, instr, instrPc, instr_vld,
    input  imem_rvalid, imem_rdata, pcNew_vld, pcNew, instr_rdy
  );

  modport slave (
    input  imem_req, imem_addr, instr, instrPc, instr_vld,
    output imem_rvalid, imem_rdata, pcNew_vld, pcNew, instr_rdy
  );
endinterface

// File: rtl/sr_fetch.sv
// Instruction fetch unit: one outstanding memory request, 2-entry {pc, instr} buffer
// toward the decoder, and redirect handling that discards a response still in flight.
module sr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  sr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  state_t      state_p0;
  logic [31:0] pc_p0;
  logic [1:0]  cnt_p1;
  logic [31:0] hd_pc_p1, hd_ins_p1;
  logic [31:0] tl_pc_p1, tl_ins_p1;
  logic        vld_p1;

  logic       pop, push, req, wr_tl;
  logic [1:0] cnt_after_pop;

  assign vld_p1 = (cnt_p1 != 2'd0);

  // A redirect suppresses both the new request and the pop, so the count used to
  // decide whether there is room is taken before the redirect is considered.
  always_comb begin
    pop           = vld_p1 & bus.instr_rdy;
    cnt_after_pop = cnt_p1 - {1'b0, pop};
    req           = !rst && (state_p0 == IDLE) && !bus.pcNew_vld && (cnt_after_pop != 2'd2);
    push          = (state_p0 == WAIT) && bus.imem_rvalid && !bus.pcNew_vld;
    wr_tl         = push && !bus.pcNew_vld &&
                    ((pop && cnt_p1 == 2'd2) || (!pop && cnt_p1 != 2'd0));
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_p0;
  assign bus.instr     = hd_ins_p1;
  assign bus.instrPc   = hd_pc_p1;
  assign bus.instr_vld = vld_p1;

  // p0 -> p1: fetch control and buffer head
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= IDLE;
      pc_p0     <= RESET_PC;
      cnt_p1    <= 2'd0;
      hd_pc_p1  <= 32'h0;
      hd_ins_p1 <= 32'h0;
    end else if (bus.pcNew_vld) begin
      cnt_p1 <= 2'd0;
      pc_p0  <= pc_align(bus.pcNew);
      if (state_p0 != IDLE)
        state_p0 <= bus.imem_rvalid ? IDLE : DROP;
    end else begin
      case (state_p0)
        IDLE: if (req) state_p0 <= WAIT;
        WAIT: if (bus.imem_rvalid) begin
          state_p0 <= IDLE;
          pc_p0    <= pc_inc(pc_p0);
        end
        DROP: if (bus.imem_rvalid) state_p0 <= IDLE;
        default: state_p0 <= IDLE;
      endcase

      if (push && pop) begin
        if (cnt_p1 == 2'd2) begin
          hd_pc_p1  <= tl_pc_p1;
          hd_ins_p1 <= tl_ins_p1;
        end else begin
          hd_pc_p1  <= pc_p0;
          hd_ins_p1 <= bus.imem_rdata;
        end
      end else if (push) begin
        if (cnt_p1 == 2'd0) begin
          hd_pc_p1  <= pc_p0;
          hd_ins_p1 <= bus.imem_rdata;
        end
        cnt_p1 <= cnt_p1 + 2'd1;
      end else if (pop) begin
        hd_pc_p1  <= tl_pc_p1;
        hd_ins_p1 <= tl_ins_p1;
        cnt_p1    <= cnt_p1 - 2'd1;
      end
    end
  end

  // p1: buffer tail, data only
  always_ff @(posedge clk) begin
    if (wr_tl) begin
      tl_pc_p1  <= pc_p0;
      tl_ins_p1 <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_sr_fetch.sv
// Directed bench for sr_fetch: reset, streaming, back-pressure, redirects, PC wrap and
// reset with a response in flight, against a latency-programmable memory model.
module tb_sr_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_fetch_if f0();
  sr_fetch_if f1();

  sr_fetch #(.RESET_PC(32'h0000_0000)) u0 (.clk(clk), .rst(rst), .bus(f0.master));
  sr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u1 (.clk(clk), .rst(rst), .bus(f1.master));

  int total = 0;
  int bad   = 0;
  int lat0  = 1;
  int cd0   = 0;
  int cd1   = 0;
  logic [31:0] ad0, ad1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Record requests of the current cycle, advance one clock, drive responses.
  task automatic go();
    #1;
    if (f0.imem_req) begin cd0 = lat0; ad0 = f0.imem_addr; end
    if (f1.imem_req) begin cd1 = 1;    ad1 = f1.imem_addr; end
    @(posedge clk);
    #1;
    f0.imem_rvalid = 1'b0; f0.imem_rdata = 32'h0;
    f1.imem_rvalid = 1'b0; f1.imem_rdata = 32'h0;
    if (cd0 > 0) begin
      cd0--;
      if (cd0 == 0) begin f0.imem_rvalid = 1'b1; f0.imem_rdata = mem(ad0); end
    end
    if (cd1 > 0) begin
      cd1--;
      if (cd1 == 0) begin f1.imem_rvalid = 1'b1; f1.imem_rdata = mem(ad1); end
    end
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1;
    f0.pcNew_vld = 1'b0;
    f0.instr_rdy = 1'b1;
    lat0 = lat;
    cd0 = 0;
    cd1 = 0;
    go();
    go();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    f0.pcNew_vld = 1'b0; f0.pcNew = 32'h0; f0.instr_rdy = 1'b1;
    f0.imem_rvalid = 1'b0; f0.imem_rdata = 32'h0;
    f1.pcNew_vld = 1'b0; f1.pcNew = 32'h0; f1.instr_rdy = 1'b1;
    f1.imem_rvalid = 1'b0; f1.imem_rdata = 32'h0;

    // reset state, then 1-cycle memory streaming and PC wrap on u1
    lat0 = 1;
    go(); go();
    #1;
    chk("rst_req", f0.imem_req, 0);
    chk("rst_vld", f0.instr_vld, 0);
    chk("rst_instr", f0.instr, 32'h0);
    chk("rst_pc", f0.instrPc, 32'h0);
    chk("u1_rst_req", f1.imem_req, 0);
    chk("u1_rst_vld", f1.instr_vld, 0);
    rst = 1'b0;
    #1;
    chk("a0_req", f0.imem_req, 1);
    chk("a0_addr", f0.imem_addr, 32'h0);
    chk("u1_a0_addr", f1.imem_addr, 32'hFFFF_FFFC);
    go(); #1;
    chk("a1_req", f0.imem_req, 0);
    chk("a1_vld", f0.instr_vld, 0);
    go(); #1;
    chk("a2_vld", f0.instr_vld, 1);
    chk("a2_instr", f0.instr, mem(32'h0));
    chk("a2_pc", f0.instrPc, 32'h0);
    chk("a2_addr", f0.imem_addr, 32'h4);
    chk("a2_req", f0.imem_req, 1);
    chk("u1_a2_pc", f1.instrPc, 32'hFFFF_FFFC);
    chk("u1_a2_instr", f1.instr, mem(32'hFFFF_FFFC));
    chk("u1_a2_addr", f1.imem_addr, 32'h0);
    go(); #1;
    chk("a3_vld", f0.instr_vld, 0);
    go(); #1;
    chk("a4_vld", f0.instr_vld, 1);
    chk("a4_pc", f0.instrPc, 32'h4);
    chk("a4_instr", f0.instr, mem(32'h4));
    chk("u1_a4_pc", f1.instrPc, 32'h0);

    // back-pressure: two words buffered, no third request, then drain in order
    do_reset(1);
    f0.instr_rdy = 1'b0;
    #1;
    chk("b0_addr", f0.imem_addr, 32'h0);
    go(); go(); #1;
    chk("b2_pc", f0.instrPc, 32'h0);
    chk("b2_addr", f0.imem_addr, 32'h4);
    go(); go(); #1;
    chk("b4_req", f0.imem_req, 0);
    chk("b4_vld", f0.instr_vld, 1);
    chk("b4_pc", f0.instrPc, 32'h0);
    go(); #1;
    chk("b5_req", f0.imem_req, 0);
    go(); #1;
    chk("b6_pc_held", f0.instrPc, 32'h0);
    chk("b6_instr_held", f0.instr, mem(32'h0));
    f0.instr_rdy = 1'b1;
    #1;
    chk("b6_req", f0.imem_req, 1);
    chk("b6_addr", f0.imem_addr, 32'h8);
    go(); #1;
    chk("b7_pc", f0.instrPc, 32'h4);
    chk("b7_instr", f0.instr, mem(32'h4));
    go(); #1;
    chk("b8_pc", f0.instrPc, 32'h8);

    // redirect during WAIT with 3-cycle memory: stale word dropped
    do_reset(3);
    chk("c0_req", f0.imem_req, 1);
    go();
    f0.pcNew_vld = 1'b1; f0.pcNew = 32'h100;
    #1;
    chk("c1_req", f0.imem_req, 0);
    go();
    f0.pcNew_vld = 1'b0;
    #1;
    chk("c2_req", f0.imem_req, 0);
    chk("c2_vld", f0.instr_vld, 0);
    go(); #1;
    chk("c3_req", f0.imem_req, 0);
    chk("c3_vld", f0.instr_vld, 0);
    go(); #1;
    chk("c4_req", f0.imem_req, 1);
    chk("c4_addr", f0.imem_addr, 32'h100);
    chk("c4_vld", f0.instr_vld, 0);
    go(); go(); go(); #1;
    chk("c7_vld", f0.instr_vld, 0);
    go(); #1;
    chk("c8_vld", f0.instr_vld, 1);
    chk("c8_pc", f0.instrPc, 32'h100);
    chk("c8_instr", f0.instr, mem(32'h100));

    // redirect coincident with response while buffer holds a word
    do_reset(1);
    f0.instr_rdy = 1'b0;
    go(); go(); #1;
    chk("d2_vld", f0.instr_vld, 1);
    go();
    f0.pcNew_vld = 1'b1; f0.pcNew = 32'h203;
    #1;
    chk("d3_req", f0.imem_req, 0);
    go();
    f0.pcNew_vld = 1'b0;
    #1;
    chk("d4_vld", f0.instr_vld, 0);
    chk("d4_req", f0.imem_req, 1);
    chk("d4_addr", f0.imem_addr, 32'h200);
    go(); go(); #1;
    chk("d6_vld", f0.instr_vld, 1);
    chk("d6_pc", f0.instrPc, 32'h200);
    chk("d6_instr", f0.instr, mem(32'h200));

    // redirect in IDLE, then reset in WAIT with the response landing after reset
    do_reset(3);
    f0.pcNew_vld = 1'b1; f0.pcNew = 32'h40;
    #1;
    chk("e0_req", f0.imem_req, 0);
    go();
    f0.pcNew_vld = 1'b0;
    #1;
    chk("e1_req", f0.imem_req, 1);
    chk("e1_addr", f0.imem_addr, 32'h40);
    go();
    rst = 1'b1;
    #1;
    chk("e2_req", f0.imem_req, 0);
    go(); #1;
    chk("e3_req", f0.imem_req, 0);
    chk("e3_vld", f0.instr_vld, 0);
    go();
    rst = 1'b0;
    #1;
    chk("e4_req", f0.imem_req, 1);
    chk("e4_addr", f0.imem_addr, 32'h0);
    chk("e4_vld", f0.instr_vld, 0);
    go(); #1;
    chk("e5_vld", f0.instr_vld, 0);
    go(); #1;
    chk("e6_vld", f0.instr_vld, 0);
    go(); #1;
    chk("e7_vld", f0.instr_vld, 0);
    go(); #1;
    chk("e8_vld", f0.instr_vld, 1);
    chk("e8_pc", f0.instrPc, 32'h0);
    chk("e8_instr", f0.instr, mem(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
